// File: rtl/nway_trace_request_scheduler_if.sv
// nway_trace_request_scheduler_if
//   Handshake bundle for the trace request scheduler.
//   slave  : scheduler side (drives *_o, samples *_i)
//   master : front end / memory / consumer side
//   Groups: alloc_* (trace front end), mem_* (cache memory port),
//           retire_* (in-order consumer), occupancy_o / proto_err_o (status).
interface nway_trace_request_scheduler_if #(
  parameter int NUM_SLOTS  = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int IDX_WIDTH  = 16
);
  localparam int TAG_WIDTH = $clog2(NUM_SLOTS);
  localparam int OCC_WIDTH = TAG_WIDTH + 1;

  logic                  alloc_valid_i;
  logic                  alloc_ready_o;
  logic [ADDR_WIDTH-1:0] alloc_addr_i;
  logic [IDX_WIDTH-1:0]  alloc_idx_i;
  logic                  mem_req_o;
  logic [ADDR_WIDTH-1:0] mem_addr_o;
  logic [TAG_WIDTH-1:0]  mem_tag_o;
  logic                  mem_gnt_i;
  logic                  mem_rvalid_i;
  logic [TAG_WIDTH-1:0]  mem_rtag_i;
  logic                  retire_valid_o;
  logic                  retire_ready_i;
  logic [ADDR_WIDTH-1:0] retire_addr_o;
  logic [IDX_WIDTH-1:0]  retire_idx_o;
  logic [OCC_WIDTH-1:0]  occupancy_o;
  logic                  proto_err_o;

  modport slave (
    input  alloc_valid_i, alloc_addr_i, alloc_idx_i,
    input  mem_gnt_i, mem_rvalid_i, mem_rtag_i, retire_ready_i,
    output alloc_ready_o, mem_req_o, mem_addr_o, mem_tag_o,
    output retire_valid_o, retire_addr_o, retire_idx_o,
    output occupancy_o, proto_err_o
  );

  modport master (
    output alloc_valid_i, alloc_addr_i, alloc_idx_i,
    output mem_gnt_i, mem_rvalid_i, mem_rtag_i, retire_ready_i,
    input  alloc_ready_o, mem_req_o, mem_addr_o, mem_tag_o,
    input  retire_valid_o, retire_addr_o, retire_idx_o,
    input  occupancy_o, proto_err_o
  );
endinterface

// File: rtl/nway_trace_request_scheduler.sv
// nway_trace_request_scheduler
//   Tracks up to NUM_SLOTS outstanding trace-driven memory requests.
//   Each slot walks FREE -> MAKE_REQ -> WAIT -> RETIRED -> FREE.
//   Memory issue is round-robin over MAKE_REQ slots; retirement follows
//   allocation order through a slot-id FIFO.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : nway_trace_request_scheduler_if.slave (alloc / mem / retire / status)
// Build option:
//   NWAY_SCHED_ADDR_FILTER_EN : block allocation of an address already held
//                               by an occupied slot until that slot retires.

package nway_sched_pkg;
  // occupied = (state != SLOT_FREE), processing = (state == SLOT_WAIT)
  typedef enum logic [1:0] {
    SLOT_FREE     = 2'd0,
    SLOT_MAKE_REQ = 2'd1,
    SLOT_WAIT     = 2'd2,
    SLOT_RETIRED  = 2'd3
  } slot_state_e;
endpackage

// One tracker slot. Enables are mutually exclusive by construction: each
// only fires from the state it names.
module nway_sched_slot
  import nway_sched_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int IDX_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  alloc_en,
  input  logic                  grant_en,
  input  logic                  rsp_en,
  input  logic                  retire_en,
  input  logic [ADDR_WIDTH-1:0] addr_d,
  input  logic [IDX_WIDTH-1:0]  idx_d,
  output slot_state_e           state_q,
  output logic [ADDR_WIDTH-1:0] addr_q,
  output logic [IDX_WIDTH-1:0]  idx_q
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SLOT_FREE;
      addr_q  <= '0;
      idx_q   <= '0;
    end else if (alloc_en) begin
      state_q <= SLOT_MAKE_REQ;
      addr_q  <= addr_d;
      idx_q   <= idx_d;
    end else if (grant_en) begin
      state_q <= SLOT_WAIT;
    end else if (rsp_en) begin
      state_q <= SLOT_RETIRED;
    end else if (retire_en) begin
      state_q <= SLOT_FREE;
    end
  end
endmodule

module nway_trace_request_scheduler
  import nway_sched_pkg::*;
#(
  parameter int NUM_SLOTS  = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int IDX_WIDTH  = 16
) (
  input logic clk,
  input logic rst_n,
  nway_trace_request_scheduler_if.slave bus
);
  localparam int TAG_WIDTH = $clog2(NUM_SLOTS);
  localparam int OCC_WIDTH = TAG_WIDTH + 1;

  slot_state_e                           slot_st [NUM_SLOTS];
  logic [NUM_SLOTS-1:0][ADDR_WIDTH-1:0]  slot_addr;
  logic [NUM_SLOTS-1:0][IDX_WIDTH-1:0]   slot_idx;
  logic [NUM_SLOTS-1:0]                  is_free, is_req, is_wait, is_done;
  logic [NUM_SLOTS-1:0]                  alloc_en, grant_en, rsp_en, retire_en;

  logic [NUM_SLOTS-1:0][TAG_WIDTH-1:0]   order_q;
  logic [TAG_WIDTH-1:0]                  head_ptr, tail_ptr, rr_ptr;
  logic [OCC_WIDTH-1:0]                  occ_q;
  logic                                  err_q;

  logic [TAG_WIDTH-1:0] alloc_slot, issue_slot, head_slot;
  logic                 alloc_ready, alloc_fire, mem_req, grant_fire;
  logic                 rsp_ok, retire_valid, retire_fire;

  always_comb begin
    for (int i = 0; i < NUM_SLOTS; i++) begin
      is_free[i] = (slot_st[i] == SLOT_FREE);
      is_req[i]  = (slot_st[i] == SLOT_MAKE_REQ);
      is_wait[i] = (slot_st[i] == SLOT_WAIT);
      is_done[i] = (slot_st[i] == SLOT_RETIRED);
    end
  end

  // Lowest-index free slot; descending scan so the smallest index wins.
  always_comb begin
    alloc_slot = '0;
    for (int i = NUM_SLOTS-1; i >= 0; i--)
      if (is_free[i]) alloc_slot = TAG_WIDTH'(i);
  end

`ifdef NWAY_SCHED_ADDR_FILTER_EN
  logic addr_hit;
  always_comb begin
    addr_hit = 1'b0;
    for (int i = 0; i < NUM_SLOTS; i++)
      if (!is_free[i] && slot_addr[i] == bus.alloc_addr_i) addr_hit = 1'b1;
  end
  assign alloc_ready = (|is_free) && !(bus.alloc_valid_i && addr_hit);
`else
  assign alloc_ready = |is_free;
`endif

  assign alloc_fire = bus.alloc_valid_i && alloc_ready;

  // First MAKE_REQ slot at or after rr_ptr; TAG_WIDTH arithmetic wraps
  // because NUM_SLOTS is a power of two.
  always_comb begin
    issue_slot = '0;
    for (int k = NUM_SLOTS-1; k >= 0; k--)
      if (is_req[rr_ptr + TAG_WIDTH'(k)]) issue_slot = rr_ptr + TAG_WIDTH'(k);
  end

  assign mem_req    = |is_req;
  assign grant_fire = mem_req && bus.mem_gnt_i;

  // A response is only legal against a slot already in WAIT; a response in
  // the same cycle as its grant still sees MAKE_REQ and is an error.
  assign rsp_ok = bus.mem_rvalid_i && is_wait[bus.mem_rtag_i];

  assign head_slot    = order_q[head_ptr];
  assign retire_valid = (occ_q != '0) && is_done[head_slot];
  assign retire_fire  = retire_valid && bus.retire_ready_i;

  for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_slot
    assign alloc_en[g]  = alloc_fire  && (alloc_slot == TAG_WIDTH'(g));
    assign grant_en[g]  = grant_fire  && (issue_slot == TAG_WIDTH'(g));
    assign rsp_en[g]    = rsp_ok      && (bus.mem_rtag_i == TAG_WIDTH'(g));
    assign retire_en[g] = retire_fire && (head_slot == TAG_WIDTH'(g));

    nway_sched_slot #(.ADDR_WIDTH(ADDR_WIDTH), .IDX_WIDTH(IDX_WIDTH)) u_slot (
      .clk       (clk),
      .rst_n     (rst_n),
      .alloc_en  (alloc_en[g]),
      .grant_en  (grant_en[g]),
      .rsp_en    (rsp_en[g]),
      .retire_en (retire_en[g]),
      .addr_d    (bus.alloc_addr_i),
      .idx_d     (bus.alloc_idx_i),
      .state_q   (slot_st[g]),
      .addr_q    (slot_addr[g]),
      .idx_q     (slot_idx[g])
    );
  end

  // Order FIFO, RR pointer, occupancy and sticky error. occ_q doubles as
  // the FIFO fill level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      order_q  <= '0;
      head_ptr <= '0;
      tail_ptr <= '0;
      rr_ptr   <= '0;
      occ_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      if (alloc_fire) begin
        order_q[tail_ptr] <= alloc_slot;
        tail_ptr          <= tail_ptr + TAG_WIDTH'(1);
      end
      if (retire_fire) head_ptr <= head_ptr + TAG_WIDTH'(1);
      if (grant_fire)  rr_ptr   <= issue_slot + TAG_WIDTH'(1);
      occ_q <= occ_q + OCC_WIDTH'(alloc_fire) - OCC_WIDTH'(retire_fire);
      if (bus.mem_rvalid_i && !rsp_ok) err_q <= 1'b1;
    end
  end

  assign bus.alloc_ready_o  = alloc_ready;
  assign bus.mem_req_o      = mem_req;
  assign bus.mem_addr_o     = mem_req ? slot_addr[issue_slot] : '0;
  assign bus.mem_tag_o      = mem_req ? issue_slot : '0;
  assign bus.retire_valid_o = retire_valid;
  assign bus.retire_addr_o  = slot_addr[head_slot];
  assign bus.retire_idx_o   = slot_idx[head_slot];
  assign bus.occupancy_o    = occ_q;
  assign bus.proto_err_o    = err_q;
endmodule

// File: tb/tb_nway_trace_request_scheduler.sv
module tb_nway_trace_request_scheduler;
  localparam int N  = 4;
  localparam int AW = 32;
  localparam int IW = 16;
  localparam int TW = 2;

  logic clk = 1'b0;
  logic rst_n;
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  nway_trace_request_scheduler_if #(.NUM_SLOTS(N), .ADDR_WIDTH(AW), .IDX_WIDTH(IW)) bus ();
  nway_trace_request_scheduler #(.NUM_SLOTS(N), .ADDR_WIDTH(AW), .IDX_WIDTH(IW)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus));

  // Reference model: slot status 0 free, 1 pending, 2 issued, 3 complete.
  int          mst  [N];
  logic [AW-1:0] maddr[N];
  logic [IW-1:0] midx [N];
  int          ord[$];
  int          rr;
  bit          perr;

  task automatic model_clear();
    for (int i = 0; i < N; i++) begin mst[i] = 0; maddr[i] = '0; midx[i] = '0; end
    ord.delete(); rr = 0; perr = 0;
  endtask

  task automatic idle_inputs();
    bus.alloc_valid_i = 0; bus.alloc_addr_i = '0; bus.alloc_idx_i = '0;
    bus.mem_gnt_i = 0; bus.mem_rvalid_i = 0; bus.mem_rtag_i = '0; bus.retire_ready_i = 0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    #1;
    model_clear();
  endtask

  task automatic alloc_one(input logic [AW-1:0] a, input logic [IW-1:0] x);
    bus.alloc_valid_i = 1; bus.alloc_addr_i = a; bus.alloc_idx_i = x;
    tick();
    bus.alloc_valid_i = 0;
  endtask

  task automatic test_reset();
    do_reset();
    if ({bus.alloc_ready_o, bus.mem_req_o, bus.retire_valid_o, bus.proto_err_o} !== 4'b1000) begin
      bad++; $display("FAIL reset_flags got=%b exp=1000",
        {bus.alloc_ready_o, bus.mem_req_o, bus.retire_valid_o, bus.proto_err_o});
    end
    total++;
    if (bus.occupancy_o !== 3'd0) begin bad++; $display("FAIL reset_occ got=%0d exp=0", bus.occupancy_o); end
    total++;
    if ({bus.mem_addr_o, bus.mem_tag_o, bus.retire_addr_o, bus.retire_idx_o} !== '0) begin
      bad++; $display("FAIL reset_data got=%h/%h/%h/%h exp=0", bus.mem_addr_o, bus.mem_tag_o,
        bus.retire_addr_o, bus.retire_idx_o);
    end
    total++;
  endtask

  task automatic test_fill();
    for (int k = 0; k < 4; k++) begin
      bus.alloc_valid_i = 1; bus.alloc_addr_i = 32'h100 + 32'(4*k); bus.alloc_idx_i = 16'(k+1);
      #1;
      if (bus.alloc_ready_o !== 1'b1) begin bad++; $display("FAIL fill_ready k=%0d got=%b exp=1", k, bus.alloc_ready_o); end
      total++;
      if (bus.mem_req_o !== (k != 0)) begin bad++; $display("FAIL fill_req k=%0d got=%b exp=%b", k, bus.mem_req_o, k != 0); end
      total++;
      if (bus.mem_tag_o !== 2'd0) begin bad++; $display("FAIL fill_tag k=%0d got=%0d exp=0", k, bus.mem_tag_o); end
      total++;
      tick();
    end
    bus.alloc_valid_i = 0;
    #1;
    if (bus.occupancy_o !== 3'd4 || bus.alloc_ready_o !== 1'b0) begin
      bad++; $display("FAIL fill_full occ=%0d ready=%b exp occ=4 ready=0", bus.occupancy_o, bus.alloc_ready_o);
    end
    total++;
    if (bus.mem_addr_o !== 32'h100) begin bad++; $display("FAIL fill_addr got=%h exp=100", bus.mem_addr_o); end
    total++;
  endtask

  task automatic test_round_robin();
    bus.mem_gnt_i = 1;
    for (int k = 0; k < 4; k++) begin
      #1;
      if (bus.mem_req_o !== 1'b1 || bus.mem_tag_o !== TW'(k) || bus.mem_addr_o !== 32'h100 + 32'(4*k)) begin
        bad++; $display("FAIL rr_issue k=%0d req=%b tag=%0d addr=%h exp tag=%0d", k, bus.mem_req_o,
          bus.mem_tag_o, bus.mem_addr_o, k);
      end
      total++;
      tick();
    end
    bus.mem_gnt_i = 0;
    #1;
    if (bus.mem_req_o !== 1'b0 || bus.occupancy_o !== 3'd4) begin
      bad++; $display("FAIL rr_done req=%b occ=%0d exp req=0 occ=4", bus.mem_req_o, bus.occupancy_o);
    end
    total++;
  endtask

  task automatic test_out_of_order();
    logic [IW-1:0] exp_idx [3];
    logic [TW-1:0] rsp_tag [3];
    exp_idx[0] = 16'd1; exp_idx[1] = 16'd2; exp_idx[2] = 16'd3;
    rsp_tag[0] = 2'd2;  rsp_tag[1] = 2'd0;  rsp_tag[2] = 2'd1;
    bus.retire_ready_i = 1;
    for (int c = 0; c < 5; c++) begin
      bus.mem_rvalid_i = (c < 3);
      bus.mem_rtag_i   = (c < 3) ? rsp_tag[c] : 2'd0;
      #1;
      if (c < 2) begin
        if (bus.retire_valid_o !== 1'b0) begin bad++; $display("FAIL ooo_wait c=%0d got=%b exp=0", c, bus.retire_valid_o); end
        total++;
      end else begin
        if (bus.retire_valid_o !== 1'b1 || bus.retire_idx_o !== exp_idx[c-2] ||
            bus.retire_addr_o !== 32'h100 + 32'(4*(c-2))) begin
          bad++; $display("FAIL ooo_retire c=%0d v=%b idx=%0d addr=%h exp idx=%0d", c, bus.retire_valid_o,
            bus.retire_idx_o, bus.retire_addr_o, exp_idx[c-2]);
        end
        total++;
      end
      tick();
    end
    bus.mem_rvalid_i = 0;
    #1;
    if (bus.retire_valid_o !== 1'b0 || bus.occupancy_o !== 3'd1) begin
      bad++; $display("FAIL ooo_head v=%b occ=%0d exp v=0 occ=1", bus.retire_valid_o, bus.occupancy_o);
    end
    total++;
    bus.mem_rvalid_i = 1; bus.mem_rtag_i = 2'd3;
    tick();
    bus.mem_rvalid_i = 0;
    #1;
    if (bus.retire_valid_o !== 1'b1 || bus.retire_idx_o !== 16'd4) begin
      bad++; $display("FAIL ooo_last v=%b idx=%0d exp v=1 idx=4", bus.retire_valid_o, bus.retire_idx_o);
    end
    total++;
    tick();
    bus.retire_ready_i = 0;
    #1;
    if (bus.occupancy_o !== 3'd0 || bus.alloc_ready_o !== 1'b1 || bus.proto_err_o !== 1'b0) begin
      bad++; $display("FAIL ooo_empty occ=%0d ready=%b err=%b exp 0/1/0", bus.occupancy_o,
        bus.alloc_ready_o, bus.proto_err_o);
    end
    total++;
  endtask

  task automatic test_error();
    bus.mem_rvalid_i = 1; bus.mem_rtag_i = 2'd3;
    #1;
    if (bus.proto_err_o !== 1'b0) begin bad++; $display("FAIL err_pre got=%b exp=0", bus.proto_err_o); end
    total++;
    tick();
    bus.mem_rvalid_i = 0;
    repeat (3) tick();
    if (bus.proto_err_o !== 1'b1) begin bad++; $display("FAIL err_sticky got=%b exp=1", bus.proto_err_o); end
    total++;
    if (bus.occupancy_o !== 3'd0 || bus.mem_req_o !== 1'b0 || bus.retire_valid_o !== 1'b0) begin
      bad++; $display("FAIL err_nochange occ=%0d req=%b rv=%b exp 0/0/0", bus.occupancy_o,
        bus.mem_req_o, bus.retire_valid_o);
    end
    total++;
  endtask

  // RR pointer came back to 0 after 4 grants: slot 0 is chosen before slot 1.
  task automatic test_rr_restart_and_reset_mid();
    alloc_one(32'h300, 16'd9);
    alloc_one(32'h304, 16'd10);
    #1;
    if (bus.mem_tag_o !== 2'd0 || bus.mem_addr_o !== 32'h300) begin
      bad++; $display("FAIL rr_restart tag=%0d addr=%h exp tag=0 addr=300", bus.mem_tag_o, bus.mem_addr_o);
    end
    total++;
    bus.mem_gnt_i = 1;
    tick();
    #1;
    if (bus.mem_tag_o !== 2'd1) begin bad++; $display("FAIL rr_next got=%0d exp=1", bus.mem_tag_o); end
    total++;
    tick();
    bus.mem_gnt_i = 0;
    alloc_one(32'h308, 16'd11);
    #1;
    if (bus.occupancy_o !== 3'd3) begin bad++; $display("FAIL mid_pre occ=%0d exp=3", bus.occupancy_o); end
    total++;
    rst_n = 0;
    #1;
    if ({bus.alloc_ready_o, bus.mem_req_o, bus.retire_valid_o, bus.proto_err_o} !== 4'b1000 ||
        bus.occupancy_o !== 3'd0) begin
      bad++; $display("FAIL mid_reset flags=%b occ=%0d exp flags=1000 occ=0",
        {bus.alloc_ready_o, bus.mem_req_o, bus.retire_valid_o, bus.proto_err_o}, bus.occupancy_o);
    end
    total++;
    tick();
    rst_n = 1;
    #1;
    model_clear();
  endtask

  task automatic test_dup_addr();
    alloc_one(32'h200, 16'd7);
    bus.alloc_valid_i = 1; bus.alloc_addr_i = 32'h200; bus.alloc_idx_i = 16'd8;
`ifdef NWAY_SCHED_ADDR_FILTER_EN
    bus.mem_gnt_i = 1;
    #1;
    if (bus.alloc_ready_o !== 1'b0) begin bad++; $display("FAIL filt_block0 got=%b exp=0", bus.alloc_ready_o); end
    total++;
    tick();
    bus.mem_gnt_i = 0; bus.mem_rvalid_i = 1; bus.mem_rtag_i = 2'd0;
    #1;
    if (bus.alloc_ready_o !== 1'b0) begin bad++; $display("FAIL filt_block1 got=%b exp=0", bus.alloc_ready_o); end
    total++;
    tick();
    bus.mem_rvalid_i = 0; bus.retire_ready_i = 1;
    #1;
    if (bus.alloc_ready_o !== 1'b0 || bus.retire_valid_o !== 1'b1) begin
      bad++; $display("FAIL filt_block2 ready=%b rv=%b exp 0/1", bus.alloc_ready_o, bus.retire_valid_o);
    end
    total++;
    tick();
    bus.retire_ready_i = 0;
    #1;
    if (bus.alloc_ready_o !== 1'b1) begin bad++; $display("FAIL filt_release got=%b exp=1", bus.alloc_ready_o); end
    total++;
    tick();
    bus.alloc_valid_i = 0;
    #1;
    if (bus.occupancy_o !== 3'd1 || bus.mem_addr_o !== 32'h200 || bus.mem_tag_o !== 2'd0) begin
      bad++; $display("FAIL filt_accept occ=%0d addr=%h tag=%0d exp 1/200/0", bus.occupancy_o,
        bus.mem_addr_o, bus.mem_tag_o);
    end
    total++;
`else
    #1;
    if (bus.alloc_ready_o !== 1'b1) begin bad++; $display("FAIL dup_ready got=%b exp=1", bus.alloc_ready_o); end
    total++;
    tick();
    bus.alloc_valid_i = 0;
    #1;
    if (bus.occupancy_o !== 3'd2 || bus.mem_addr_o !== 32'h200) begin
      bad++; $display("FAIL dup_two occ=%0d addr=%h exp 2/200", bus.occupancy_o, bus.mem_addr_o);
    end
    total++;
`endif
  endtask

  task automatic test_random();
    bit            e_ready, e_req, e_rv, g_fire, a_fire, r_fire, rsp_ok;
    logic [TW-1:0] e_tag;
    int            a_slot, s, head;
    int            wl[$];
    do_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (cyc % 700 == 699) do_reset();
      bus.alloc_valid_i  = ($urandom_range(0, 1) == 1);
      bus.alloc_addr_i   = 32'h400 + 32'(4 * $urandom_range(0, 5));
      bus.alloc_idx_i    = 16'($urandom);
      bus.mem_gnt_i      = ($urandom_range(0, 2) != 0);
      bus.retire_ready_i = ($urandom_range(0, 3) != 0);
      bus.mem_rvalid_i   = ($urandom_range(0, 1) == 1);
      wl.delete();
      for (int i = 0; i < N; i++) if (mst[i] == 2) wl.push_back(i);
      if (wl.size() > 0 && $urandom_range(0, 99) != 0) bus.mem_rtag_i = TW'(wl[$urandom_range(0, wl.size()-1)]);
      else bus.mem_rtag_i = TW'($urandom_range(0, N-1));

      // Expected outputs from model state and current inputs.
      e_ready = 0;
      for (int i = 0; i < N; i++) if (mst[i] == 0) e_ready = 1;
`ifdef NWAY_SCHED_ADDR_FILTER_EN
      if (bus.alloc_valid_i)
        for (int i = 0; i < N; i++) if (mst[i] != 0 && maddr[i] == bus.alloc_addr_i) e_ready = 0;
`endif
      e_req = 0; e_tag = '0;
      for (int k = 0; k < N; k++) begin
        s = (rr + k) % N;
        if (!e_req && mst[s] == 1) begin e_req = 1; e_tag = TW'(s); end
      end
      head = (ord.size() > 0) ? ord[0] : 0;
      e_rv = (ord.size() > 0) && (mst[head] == 3);
      #1;
      if (bus.alloc_ready_o !== e_ready) begin bad++; $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", cyc, bus.alloc_ready_o, e_ready); end
      total++;
      if (bus.mem_req_o !== e_req) begin bad++; $display("FAIL rnd_req cyc=%0d got=%b exp=%b", cyc, bus.mem_req_o, e_req); end
      total++;
      if (e_req) begin
        if (bus.mem_tag_o !== e_tag || bus.mem_addr_o !== maddr[e_tag]) begin
          bad++; $display("FAIL rnd_issue cyc=%0d tag=%0d addr=%h exp tag=%0d addr=%h", cyc,
            bus.mem_tag_o, bus.mem_addr_o, e_tag, maddr[e_tag]);
        end
        total++;
      end
      if (bus.retire_valid_o !== e_rv) begin bad++; $display("FAIL rnd_rv cyc=%0d got=%b exp=%b", cyc, bus.retire_valid_o, e_rv); end
      total++;
      if (e_rv) begin
        if (bus.retire_addr_o !== maddr[head] || bus.retire_idx_o !== midx[head]) begin
          bad++; $display("FAIL rnd_retire cyc=%0d addr=%h idx=%0d exp addr=%h idx=%0d", cyc,
            bus.retire_addr_o, bus.retire_idx_o, maddr[head], midx[head]);
        end
        total++;
      end
      if (bus.occupancy_o !== 3'(ord.size())) begin bad++; $display("FAIL rnd_occ cyc=%0d got=%0d exp=%0d", cyc, bus.occupancy_o, ord.size()); end
      total++;
      if (bus.proto_err_o !== perr) begin bad++; $display("FAIL rnd_err cyc=%0d got=%b exp=%b", cyc, bus.proto_err_o, perr); end
      total++;

      // Decide every event from the pre-edge state, then apply.
      a_fire = bus.alloc_valid_i && e_ready;
      a_slot = -1;
      for (int i = N-1; i >= 0; i--) if (mst[i] == 0) a_slot = i;
      g_fire = e_req && bus.mem_gnt_i;
      rsp_ok = bus.mem_rvalid_i && (mst[int'(bus.mem_rtag_i)] == 2);
      r_fire = e_rv && bus.retire_ready_i;
      if (rsp_ok) mst[int'(bus.mem_rtag_i)] = 3;
      else if (bus.mem_rvalid_i) perr = 1;
      if (g_fire) begin mst[int'(e_tag)] = 2; rr = (int'(e_tag) + 1) % N; end
      if (r_fire) begin mst[head] = 0; void'(ord.pop_front()); end
      if (a_fire) begin
        mst[a_slot] = 1; maddr[a_slot] = bus.alloc_addr_i; midx[a_slot] = bus.alloc_idx_i;
        ord.push_back(a_slot);
      end
      @(posedge clk); #1;
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    rst_n = 0;
    model_clear();
    test_reset();
    test_fill();
    test_round_robin();
    test_out_of_order();
    test_error();
    test_rr_restart_and_reset_mid();
    test_dup_addr();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/nway_trace_request_scheduler.md
Name: nway_trace_request_scheduler

Overview:
- Sequences outstanding trace-driven memory requests through a small table of tracker slots, NUM_SLOTS deep.
- Each slot holds occupied, processing, mem_addr and trace_index, and steps through MAKE_REQUEST -> WAIT_FOR_PROCESSING -> REQUEST_RETIRED -> free.
- Memory issue is round-robin among pending slots; retirement is strictly in allocation order.
- Sits between the trace repository front end (allocation) and the n-way cache memory port.

Parameters:
- NUM_SLOTS, 4, number of tracker slots; power of two, >=2.
- ADDR_WIDTH, 32, width of mem_addr (matches DATA_ADDR_WIDTH).
- IDX_WIDTH, 16, width of trace_index (clog2 of 65536 trace entries).
- TAG_WIDTH, clog2(NUM_SLOTS), width of the slot tag on the memory port; derived, not overridable.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- alloc_valid_i  in  1  new request offered
- alloc_ready_o  out  1  slot available; a transfer occurs when valid&&ready
- alloc_addr_i  in  ADDR_WIDTH  request address
- alloc_idx_i  in  IDX_WIDTH  trace index
- mem_req_o  out  1  memory request valid
- mem_addr_o  out  ADDR_WIDTH  address of the selected slot
- mem_tag_o  out  TAG_WIDTH  slot id of the selected slot
- mem_gnt_i  in  1  request accepted this cycle
- mem_rvalid_i  in  1  response valid
- mem_rtag_i  in  TAG_WIDTH  slot id of the response
- retire_valid_o  out  1  oldest entry is complete
- retire_ready_i  in  1  consumer accepts the retired entry
- retire_addr_o  out  ADDR_WIDTH  address of the retired entry
- retire_idx_o  out  IDX_WIDTH  trace index of the retired entry
- occupancy_o  out  clog2(NUM_SLOTS)+1  number of occupied slots
- proto_err_o  out  1  sticky protocol-error flag

Behaviour:
- Reset (async assert, sync release):
  - all slots free, all slot fields 0; order FIFO empty; round-robin pointer 0; proto_err_o 0.
  - Resulting output values: alloc_ready_o=1, mem_req_o=0, retire_valid_o=0, occupancy_o=0, mem/retire data 0.
- Reset mid-operation discards all slots. In-flight responses arriving after release are flagged by the response error rule below.
- Per-slot state encoding: FREE (occupied=0), MAKE_REQUEST (occupied=1, processing=0), WAIT_FOR_PROCESSING (processing=1), REQUEST_RETIRED.
- Allocation:
  - alloc_ready_o = any slot FREE, evaluated on registered state.
  - On transfer, the lowest-index FREE slot captures addr/idx and enters MAKE_REQUEST at the next edge. Its id is pushed to the tail of the order FIFO (depth NUM_SLOTS).
- Issue:
  - mem_req_o is high when any slot is in MAKE_REQUEST.
  - The selected slot is the first MAKE_REQUEST slot at or after the RR pointer, wrapping around.
  - mem_addr_o and mem_tag_o are combinational from registered state and stay stable while mem_req_o is high and mem_gnt_i is low.
  - On mem_gnt_i: the slot enters WAIT_FOR_PROCESSING and the RR pointer becomes selected+1 mod NUM_SLOTS. mem_gnt_i while mem_req_o=0 is ignored.
- Response:
  - mem_rvalid_i with mem_rtag_i naming a slot in WAIT_FOR_PROCESSING (registered state) moves that slot to REQUEST_RETIRED.
  - A tag naming any other state sets proto_err_o and changes no state. This includes a response in the same cycle as that slot's grant.
- Retire:
  - retire_valid_o = head-of-FIFO slot is in REQUEST_RETIRED. retire_addr_o and retire_idx_o come from the head slot.
  - On retire_valid_o && retire_ready_i: the slot returns to FREE and the FIFO pops.
  - Completed younger slots wait behind an incomplete head.
- Simultaneous events:
  - Allocate, grant, response and retire may all occur in one cycle on different slots.
  - A slot freed by retire is not allocatable until the next cycle.
  - occupancy_o = registered count: +1 on alloc, -1 on retire, net 0 when both occur.
- Latency: alloc to mem_req_o is 1 cycle minimum; response to retire_valid_o is 1 cycle when the slot is at the head.

Optional Feature:
- NWAY_SCHED_ADDR_FILTER_EN defined:
  - alloc_ready_o is additionally held low while alloc_valid_i is high and alloc_addr_i equals the mem_addr of any occupied slot.
  - The request stalls until the matching slot retires, so no two outstanding slots share an address.
- Undefined: no address comparison; duplicate addresses occupy separate slots.

Test Plan:
- Reset then idle: rst_n low mid-run with 3 slots occupied -> immediately alloc_ready_o=1, mem_req_o=0, retire_valid_o=0, occupancy_o=0.
- Fill: allocate addr 0x100/0x104/0x108/0x10C with idx 1..4, mem_gnt_i held low -> occupancy_o=4, alloc_ready_o=0 on the 4th cycle, mem_tag_o=0 throughout.
- Round-robin: 4 pending slots, mem_gnt_i held high -> tags issued 0,1,2,3 on consecutive cycles; RR pointer returns to 0.
- Out-of-order response: responses arrive with tags 2,0,1 -> retire_valid_o stays low until tag 0 returns. Retires then come out idx 1,2,3 on consecutive cycles with retire_ready_i=1.
- Error: mem_rvalid_i with tag 3 while slot 3 is FREE -> proto_err_o=1 and stays 1; no slot state changes.
- With NWAY_SCHED_ADDR_FILTER_EN: allocate 0x200, then offer 0x200 again -> alloc_ready_o=0 until the first retires, then accepted the following cycle.
